// File: rtl/wb_accel_dispatch.sv
// wb_accel_dispatch: Wishbone slave front-end for the crypto accelerator array.
// Decodes MGMT-core accesses into NUM_CH accelerator channels plus one status
// page, forwards channel accesses over a valid/ready request and a response
// strobe (one access outstanding), and guards each with a response timeout,
// a sticky per-channel error flag and an interrupt.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   wbs_*                    Wishbone classic slave (cyc/stb/we/sel/adr/dat/ack)
//   ch_req_valid/ready       one-hot request handshake per channel
//   ch_we/addr/wdata/sel     shared request payload (addr = word offset [11:2])
//   ch_resp_valid/data       per-channel completion strobe and read data
//   irq                      registered OR of the timeout flags
//
// state  | meaning
// IDLE   | waiting for cyc&stb, decodes and latches the access
// REQ    | ch_req_valid asserted to the selected channel until ready
// WAIT   | request taken, waiting for that channel's response
// ACK    | single-cycle Wishbone ack with read data
// DRAIN  | master aborted after handoff; absorb response or time out, no ack

module wb_accel_dispatch #(
    parameter int          NUM_CH   = 4,
    parameter logic [7:0]  BASE_HI  = 8'h30,
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [NUM_CH-1:0]      ch_req_valid,
    input  logic [NUM_CH-1:0]      ch_req_ready,
    output logic                   ch_we,
    output logic [9:0]             ch_addr,
    output logic [31:0]            ch_wdata,
    output logic [3:0]             ch_sel,
    input  logic [NUM_CH-1:0]      ch_resp_valid,
    input  logic [32*NUM_CH-1:0]   ch_resp_data,
    output logic                   irq
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ACK, S_DRAIN} state_t;

    localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [9:0]         addr_q, addr_d;
    logic [3:0]         ch_q, ch_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [NUM_CH-1:0]  flag_q, flag_d;
    logic               irq_q;

    logic               sel_ready, sel_resp, timeout_hit, set_flag, hit;
    logic [31:0]        sel_rdata;
    logic [3:0]         adr_ch;
    logic               unused_adr;

    assign unused_adr = ^{wbs_adr_i[23:16], wbs_adr_i[1:0]};
    assign hit        = (wbs_adr_i[31:24] == BASE_HI);
    assign adr_ch     = wbs_adr_i[15:12];

    // Mux the selected channel's handshake inputs; only ch_q's lane is observed.
    always_comb begin
        sel_ready = 1'b0;
        sel_resp  = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == 4'(i)) begin
                sel_ready = ch_req_ready[i];
                sel_resp  = ch_resp_valid[i];
                sel_rdata = ch_resp_data[32*i +: 32];
            end
        end
    end

    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        flag_d   = flag_q;
        set_flag = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    wdata_d = wbs_dat_i;
                    addr_d  = wbs_adr_i[11:2];
                    ch_d    = adr_ch;
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (hit && adr_ch < NUM_CH_W) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_ACK;
                        if (hit && adr_ch == NUM_CH_W) begin
                            if (wbs_we_i) begin
                                if (wbs_adr_i[11:2] == 10'd0) begin
                                    for (int i = 0; i < NUM_CH; i++) begin
                                        if (wbs_dat_i[i] && wbs_sel_i[i/8]) flag_d[i] = 1'b0;
                                    end
                                end
                            end else if (wbs_adr_i[11:2] == 10'd0) begin
                                rdata_d = 32'(flag_q);
                            end else if (wbs_adr_i[11:2] == 10'd1) begin
                                rdata_d = {16'h0, 8'(NUM_CH), 8'(TIMEOUT)};
                            end
                        end
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (!wbs_cyc_i) begin
                    // A request taken on the abort edge still owes a response.
                    state_d = sel_ready ? S_DRAIN : S_IDLE;
                end else if (sel_ready) begin
                    state_d = S_WAIT;
                end else if (timeout_hit) begin
                    rdata_d  = ERR_DATA;
                    set_flag = 1'b1;
                    state_d  = S_ACK;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (!wbs_cyc_i) begin
                    if (sel_resp) begin
                        state_d = S_IDLE;
                    end else if (timeout_hit) begin
                        set_flag = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (sel_resp) begin
                    rdata_d = we_q ? 32'h0 : sel_rdata;
                    state_d = S_ACK;
                end else if (timeout_hit) begin
                    rdata_d  = ERR_DATA;
                    set_flag = 1'b1;
                    state_d  = S_ACK;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 8'd1;
                if (sel_resp) begin
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    set_flag = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Applied after any clear so a set on the same edge wins.
        if (set_flag) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_q == 4'(i)) flag_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            flag_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            flag_q  <= flag_d;
            irq_q   <= |flag_q;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_req_valid[i] = (state_q == S_REQ) && (ch_q == 4'(i));
        end
    end

    assign wbs_ack_o = (state_q == S_ACK);
    assign wbs_dat_o = wbs_ack_o ? rdata_q : 32'h0;
    assign ch_we     = we_q;
    assign ch_addr   = addr_q;
    assign ch_wdata  = wdata_q;
    assign ch_sel    = sel_q;
    assign irq       = irq_q;

endmodule
